onehot_req_sequencer: RTL and testbench

ONEHOT_REQ_SEQUENCER -- requirements
Module: onehot_req_sequencer

---
 rtl/onehot_req_sequencer.sv | 166 ++++++++++++++++
 tb/tb_onehot_req_sequencer.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/onehot_req_sequencer.sv
// ---------------------------------------------------------------------------
// onehot_req_sequencer
//
// Purpose: records per-source event pulses in a pending set. It presents one
// pending source at a time as a registered one-hot grant to a downstream
// 8-to-3 encoder stage, using a valid/ready handshake. Arbitration is either
// fixed priority (bit 7 highest) or descending round-robin. A sticky flag
// reports events that were lost because their source was already pending.
//
// Parameters:
//   RR        0 = fixed priority (highest index wins), 1 = round-robin
//
// Ports:
//   clk       in   1  single clock, rising edge
//   rst_n     in   1  synchronous active-low reset
//   req       in   8  per-source event pulses (one cycle = one event)
//   ready     in   1  downstream accepts grant_oh this cycle
//   clr_ovf   in   1  clears the overflow flag (a same-edge drop wins)
//   grant_oh  out  8  registered one-hot grant, 8'h00 while valid is low
//   valid     out  1  grant_oh holds a valid one-hot value
//   pending   out  8  registered recorded, not-yet-granted events
//   pend_cnt  out  4  popcount of pending (0..8)
//   overflow  out  1  sticky: at least one event was dropped
// ---------------------------------------------------------------------------
module onehot_req_sequencer #(
  parameter int unsigned RR = 0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] req,
  input  logic       ready,
  input  logic       clr_ovf,
  output logic [7:0] grant_oh,
  output logic       valid,
  output logic [7:0] pending,
  output logic [3:0] pend_cnt,
  output logic       overflow
);

  typedef enum logic [0:0] {
    IDLE    = 1'b0,
    PRESENT = 1'b1
  } state_e;

  // Number of set bits in an 8-bit vector.
  function automatic logic [3:0] popcount8(input logic [7:0] v);
    logic [3:0] cnt;
    cnt = 4'd0;
    for (int i = 0; i < 8; i++) begin
      cnt = cnt + {3'd0, v[i]};
    end
    return cnt;
  endfunction

  state_e     state_q;
  logic [7:0] pending_q;
  logic [7:0] grant_q;
  logic       valid_q;
  logic       ovf_q;
  logic [2:0] ptr_q;

  logic [2:0] sel_idx_s;
  logic [7:0] sel_oh_s;
  logic       found_s;
  logic [2:0] cand_s;
  logic       load_s;
  logic [7:0] load_clr_s;
  logic [7:0] pending_d;
  logic       drop_s;
  logic       ovf_d;

  // Pick the next source from registered pending only, so a new req is never
  // grantable on the edge that records it.
  always_comb begin
    sel_idx_s = 3'd0;
    found_s   = 1'b0;
    cand_s    = 3'd0;
    if (RR == 0) begin
      // Ascending scan: the last set bit seen is the highest index.
      for (int i = 0; i < 8; i++) begin
        sel_idx_s = pending_q[i] ? 3'(i) : sel_idx_s;
      end
    end else begin
      // Descend from ptr-1 with 3-bit wrap; the final candidate (k=8) is ptr
      // itself, so every bit is visited exactly once.
      for (int k = 1; k <= 8; k++) begin
        cand_s = ptr_q - 3'(k);
        if (!found_s && pending_q[cand_s]) begin
          sel_idx_s = cand_s;
          found_s   = 1'b1;
        end else begin
          found_s   = found_s;
        end
      end
    end
    sel_oh_s = 8'b0000_0001 << sel_idx_s;
  end

  // A new grant loads when something is pending and the output slot is
  // either empty or being consumed this edge.
  always_comb begin
    load_s     = (pending_q != 8'h00) && ((state_q == IDLE) || ready);
    load_clr_s = load_s ? sel_oh_s : 8'h00;
    // Set wins over clear: a bit granted and re-requested on the same edge
    // stays pending and is not a drop.
    pending_d  = (pending_q & ~load_clr_s) | req;
    drop_s     = |(req & pending_q & ~load_clr_s);
    ovf_d      = drop_s | (ovf_q & ~clr_ovf);
  end

  // Handshake FSM with registered grant/valid, pending set and sticky flag.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      pending_q <= 8'h00;
      grant_q   <= 8'h00;
      valid_q   <= 1'b0;
      ovf_q     <= 1'b0;
      ptr_q     <= 3'd0;
    end else begin
      pending_q <= pending_d;
      ovf_q     <= ovf_d;
      case (state_q)
        IDLE: begin
          if (load_s) begin
            grant_q <= sel_oh_s;
            valid_q <= 1'b1;
            ptr_q   <= sel_idx_s;
            state_q <= PRESENT;
          end else begin
            grant_q <= 8'h00;
            valid_q <= 1'b0;
          end
        end
        PRESENT: begin
          if (ready) begin
            if (load_s) begin
              grant_q <= sel_oh_s;
              valid_q <= 1'b1;
              ptr_q   <= sel_idx_s;
            end else begin
              grant_q <= 8'h00;
              valid_q <= 1'b0;
              state_q <= IDLE;
            end
          end else begin
            grant_q <= grant_q;
            valid_q <= valid_q;
          end
        end
        default: begin
          grant_q <= 8'h00;
          valid_q <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign grant_oh = grant_q;
  assign valid    = valid_q;
  assign pending  = pending_q;
  assign pend_cnt = popcount8(pending_q);
  assign overflow = ovf_q;

endmodule

// File: tb/tb_onehot_req_sequencer.sv
// ---------------------------------------------------------------------------
// tb_onehot_req_sequencer
//
// Directed testbench. One fixed-priority instance (f_*) and one round-robin
// instance (r_*) share the same stimulus. Inputs change 1 time unit after a
// rising edge, and outputs are sampled at that same point.
// ---------------------------------------------------------------------------
module tb_onehot_req_sequencer;

  logic       clk;
  logic       rst_n;
  logic [7:0] req;
  logic       ready;
  logic       clr_ovf;

  logic [7:0] f_grant, r_grant;
  logic       f_valid, r_valid;
  logic [7:0] f_pend,  r_pend;
  logic [3:0] f_cnt,   r_cnt;
  logic       f_ovf,   r_ovf;

  int checks;
  int errors;

  onehot_req_sequencer #(.RR(0)) u_fix (
    .clk(clk), .rst_n(rst_n), .req(req), .ready(ready), .clr_ovf(clr_ovf),
    .grant_oh(f_grant), .valid(f_valid), .pending(f_pend),
    .pend_cnt(f_cnt), .overflow(f_ovf)
  );

  onehot_req_sequencer #(.RR(1)) u_rr (
    .clk(clk), .rst_n(rst_n), .req(req), .ready(ready), .clr_ovf(clr_ovf),
    .grant_oh(r_grant), .valid(r_valid), .pending(r_pend),
    .pend_cnt(r_cnt), .overflow(r_ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Advance one rising edge and settle.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n   = 1'b0;
    req     = 8'h00;
    ready   = 1'b0;
    clr_ovf = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  initial begin
    checks  = 0;
    errors  = 0;
    rst_n   = 1'b0;
    req     = 8'h00;
    ready   = 1'b0;
    clr_ovf = 1'b0;
    #1;
    do_reset();
    check("rst_grant", {24'd0, f_grant}, 32'h00);
    check("rst_valid", {31'd0, f_valid}, 32'h0);
    check("rst_pend",  {24'd0, f_pend},  32'h00);
    check("rst_cnt",   {28'd0, f_cnt},   32'h0);
    check("rst_ovf",   {31'd0, f_ovf},   32'h0);

    // Two-source burst drains in priority order with a two-cycle latency.
    ready = 1'b1;
    req   = 8'h81;
    tick();
    req = 8'h00;
    check("b81_pend_t1", {24'd0, f_pend}, 32'h81);
    check("b81_cnt_t1",  {28'd0, f_cnt},  32'h2);
    check("b81_valid_t1", {31'd0, f_valid}, 32'h0);
    tick();
    check("b81_grant_t2", {24'd0, f_grant}, 32'h80);
    check("b81_valid_t2", {31'd0, f_valid}, 32'h1);
    check("b81_pend_t2",  {24'd0, f_pend},  32'h01);
    tick();
    check("b81_grant_t3", {24'd0, f_grant}, 32'h01);
    check("b81_valid_t3", {31'd0, f_valid}, 32'h1);
    tick();
    check("b81_valid_t4", {31'd0, f_valid}, 32'h0);
    check("b81_grant_t4", {24'd0, f_grant}, 32'h00);

    // Hold with ready low, re-record, then drop; a drop beats clr_ovf.
    do_reset();
    ready = 1'b0;
    req   = 8'h10;
    tick();
    req = 8'h00;
    tick();
    check("hold_grant", {24'd0, f_grant}, 32'h10);
    check("hold_pend0", {24'd0, f_pend},  32'h00);
    req = 8'h10;
    tick();
    req = 8'h00;
    check("hold_pend1", {24'd0, f_pend},  32'h10);
    check("hold_ovf1",  {31'd0, f_ovf},   32'h0);
    check("hold_grant1", {24'd0, f_grant}, 32'h10);
    req = 8'h10;
    tick();
    req = 8'h00;
    check("drop_ovf", {31'd0, f_ovf}, 32'h1);
    req     = 8'h10;
    clr_ovf = 1'b1;
    tick();
    req = 8'h00;
    check("drop_vs_clr", {31'd0, f_ovf}, 32'h1);
    tick();
    clr_ovf = 1'b0;
    check("clr_ovf", {31'd0, f_ovf}, 32'h0);
    tick();
    check("ovf_stays_clear", {31'd0, f_ovf}, 32'h0);
    ready = 1'b1;
    tick();
    check("hold_regrant", {24'd0, f_grant}, 32'h10);
    check("hold_regrant_pend", {24'd0, f_pend}, 32'h00);
    tick();
    check("hold_idle", {31'd0, f_valid}, 32'h0);

    // Round-robin full sweep, back-to-back.
    do_reset();
    ready = 1'b1;
    req   = 8'hFF;
    tick();
    req = 8'h00;
    check("rr_cnt_full", {28'd0, r_cnt}, 32'h8);
    for (int i = 0; i < 8; i++) begin
      tick();
      check("rr_sweep_grant", {24'd0, r_grant}, 32'h80 >> i);
      check("rr_sweep_valid", {31'd0, r_valid}, 32'h1);
      check("rr_sweep_cnt",   {28'd0, r_cnt},   32'(7 - i));
    end
    tick();
    check("rr_sweep_end", {31'd0, r_valid}, 32'h0);

    // No preemption of a held grant by a later higher-priority request.
    do_reset();
    ready = 1'b0;
    req   = 8'h01;
    tick();
    req = 8'h80;
    tick();
    req = 8'h00;
    check("nopre_grant", {24'd0, f_grant}, 32'h01);
    check("nopre_pend",  {24'd0, f_pend},  32'h80);
    tick();
    check("nopre_held", {24'd0, f_grant}, 32'h01);
    ready = 1'b1;
    tick();
    check("nopre_next", {24'd0, f_grant}, 32'h80);
    tick();
    check("nopre_idle", {31'd0, f_valid}, 32'h0);

    // Round-robin moves past the last winner; fixed priority does not.
    do_reset();
    ready = 1'b0;
    req   = 8'h81;
    tick();
    req = 8'h00;
    tick();
    check("rrvf_first_r", {24'd0, r_grant}, 32'h80);
    req = 8'h80;
    tick();
    req = 8'h00;
    check("rrvf_pend_r", {24'd0, r_pend}, 32'h81);
    ready = 1'b1;
    tick();
    ready = 1'b0;
    check("rrvf_fix_grant", {24'd0, f_grant}, 32'h80);
    check("rrvf_rr_grant",  {24'd0, r_grant}, 32'h01);
    check("rrvf_rr_pend",   {24'd0, r_pend},  32'h80);

    // Same-edge load and re-request keeps the bit pending without a drop.
    do_reset();
    ready = 1'b0;
    req   = 8'h04;
    tick();
    check("same_pend_pre", {24'd0, f_pend}, 32'h04);
    tick();
    req = 8'h00;
    check("same_grant", {24'd0, f_grant}, 32'h04);
    check("same_pend",  {24'd0, f_pend},  32'h04);
    check("same_ovf",   {31'd0, f_ovf},   32'h0);

    // Reset in the middle of a held handshake with overflow set.
    do_reset();
    ready = 1'b0;
    req   = 8'h1F;
    tick();
    req = 8'h00;
    tick();
    check("mid_grant", {24'd0, f_grant}, 32'h10);
    check("mid_pend",  {24'd0, f_pend},  32'h0F);
    req = 8'h01;
    tick();
    req = 8'h00;
    check("mid_ovf", {31'd0, f_ovf}, 32'h1);
    rst_n = 1'b0;
    req   = 8'hFF;
    ready = 1'b1;
    tick();
    req   = 8'h00;
    rst_n = 1'b1;
    check("mid_rst_grant", {24'd0, f_grant}, 32'h00);
    check("mid_rst_valid", {31'd0, f_valid}, 32'h0);
    check("mid_rst_pend",  {24'd0, f_pend},  32'h00);
    check("mid_rst_cnt",   {28'd0, f_cnt},   32'h0);
    check("mid_rst_ovf",   {31'd0, f_ovf},   32'h0);
    tick();
    check("mid_rst_discard", {24'd0, f_pend}, 32'h00);
    check("mid_rst_rrvalid", {31'd0, r_valid}, 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
